// File: rtl/def_pack.sv
// rtl/def_pack.sv - shared types and sizes for the block-memory arbiter
package def_pack;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } mem_owner_t;

    typedef struct packed {
        logic       valid;
        mem_owner_t owner;
        logic       write;
    } mem_tag_t;

endpackage

// File: rtl/block_mem_arbiter.sv
// rtl/block_mem_arbiter.sv - fetch/data arbiter in front of the single-port block memory
module block_mem_arbiter
    import def_pack::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [DATA_W-1:0] I_RDATA,

    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,

    output logic              MEM_ENABLED,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic              MEM_WRITE_ENABLE,
    output logic [DATA_W-1:0] MEM_WRITE_DATA,
    input  logic [DATA_W-1:0] MEM_READ_DATA
);

    localparam logic [WAIT_CNT_W-1:0] STARVE_THRESH = WAIT_CNT_W'(STARVE_LIMIT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX      = '1;

    mem_tag_t              tag_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  starve;
    logic                  i_gnt;
    logic                  d_gnt;

    // Grant decision: D wins unless I has been denied long enough; nothing is granted during reset.
    always_comb begin
        starve = (wait_cnt >= STARVE_THRESH);
        d_gnt  = 1'b0;
        i_gnt  = 1'b0;
        if (!RST) begin
            d_gnt = D_REQ & ~(I_REQ & starve);
            i_gnt = I_REQ & ~d_gnt;
        end
    end

    assign I_GNT = i_gnt;
    assign D_GNT = d_gnt;

    // Memory drive: steer the winning port's fields to the memory, zeros when nobody is granted.
    always_comb begin
        MEM_ENABLED      = i_gnt | d_gnt;
        MEM_ADDRESS      = '0;
        MEM_WRITE_ENABLE = 1'b0;
        MEM_WRITE_DATA   = '0;
        if (d_gnt) begin
            MEM_ADDRESS      = D_ADDR;
            MEM_WRITE_ENABLE = D_WE;
            MEM_WRITE_DATA   = D_WE ? D_WDATA : '0;
        end else if (i_gnt) begin
            MEM_ADDRESS = I_ADDR;
        end
    end

    // Response tag follows the grant by one cycle; aging counter tracks how long I has been refused.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_q    <= '{valid: 1'b0, owner: OWNER_I, write: 1'b0};
            wait_cnt <= '0;
        end else begin
            tag_q.valid <= i_gnt | d_gnt;
            tag_q.owner <= d_gnt ? OWNER_D : OWNER_I;
            tag_q.write <= d_gnt & D_WE;
            if (I_REQ && !i_gnt) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Response routing: RST masks the tag so an access granted just before reset never answers.
    always_comb begin
        I_RVALID = tag_q.valid & (tag_q.owner == OWNER_I) & ~RST;
        D_RVALID = tag_q.valid & (tag_q.owner == OWNER_D) & ~RST;
        I_RDATA  = I_RVALID ? MEM_READ_DATA : '0;
        D_RDATA  = (D_RVALID && !tag_q.write) ? MEM_READ_DATA : '0;
    end

endmodule

// File: tb/tb_block_mem_arbiter.sv
// tb/tb_block_mem_arbiter.sv - scoreboard bench for block_mem_arbiter
module tb_block_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        i_req;
    logic [9:0]  i_addr;
    logic        I_GNT;
    logic        I_RVALID;
    logic [31:0] I_RDATA;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        D_GNT;
    logic        D_RVALID;
    logic [31:0] D_RDATA;
    logic        MEM_ENABLED;
    logic [9:0]  MEM_ADDRESS;
    logic        MEM_WRITE_ENABLE;
    logic [31:0] MEM_WRITE_DATA;
    logic [31:0] mem_rdata;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } resp_t;

    resp_t       sbq[$];
    resp_t       e;
    logic [31:0] mem[1024];
    logic [31:0] ref_mem[1024];
    bit          mem_loaded;
    int          checks;
    int          errors;

    block_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .MEM_ENABLED(MEM_ENABLED), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITE_ENABLE(MEM_WRITE_ENABLE), .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_READ_DATA(mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
    endfunction

    // Block memory model: registered read, read-before-write within one access.
    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (MEM_ENABLED) begin
            if (MEM_WRITE_ENABLE) mem[MEM_ADDRESS] <= MEM_WRITE_DATA;
            mem_rdata <= mem[MEM_ADDRESS];
        end
    end

    task automatic drive(input logic ir, input logic [9:0] ia, input logic dr, input logic dw,
                         input logic [9:0] da, input logic [31:0] dd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic sb_push(input bit ei, input bit ed);
        if (ei) sbq.push_back('{is_d: 1'b0, data: ref_mem[i_addr]});
        if (ed) begin
            if (d_we) begin
                ref_mem[d_addr] = d_wdata;
                sbq.push_back('{is_d: 1'b1, data: 32'h0});
            end else begin
                sbq.push_back('{is_d: 1'b1, data: ref_mem[d_addr]});
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b1, 10'd1, 1'b1, 1'b1, 10'd2, 32'h1234_5678);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (I_GNT !== 1'b0 || D_GNT !== 1'b0 || MEM_ENABLED !== 1'b0 || MEM_WRITE_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got i_gnt=%b d_gnt=%b en=%b we=%b want all 0", I_GNT, D_GNT, MEM_ENABLED, MEM_WRITE_ENABLE);
        end
        checks++;
        if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid got i=%b d=%b want 0 0", I_RVALID, D_RVALID);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0);
        @(negedge CLK);
        checks++;
        if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0 || I_GNT !== 1'b0 || D_GNT !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got i_v=%b d_v=%b i_g=%b d_g=%b want all 0", I_RVALID, D_RVALID, I_GNT, D_GNT);
        end
    endtask

    task automatic test_fetch();
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            drive(k == 0, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0);
            @(negedge CLK);
            checks++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (I_RVALID !== !e.is_d || D_RVALID !== e.is_d || (e.is_d ? D_RDATA : I_RDATA) !== e.data) begin
                    errors++;
                    $display("FAIL fetch_resp got i_v=%b d_v=%b i_d=%h d_d=%h want d=%b data=%h", I_RVALID, D_RVALID, I_RDATA, D_RDATA, e.is_d, e.data);
                end
            end else if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0) begin
                errors++;
                $display("FAIL fetch_spurious got i_v=%b d_v=%b want 0 0", I_RVALID, D_RVALID);
            end
            checks++;
            if (I_GNT !== (k == 0) || D_GNT !== 1'b0 || MEM_ADDRESS !== (k == 0 ? 10'd5 : 10'd0)) begin
                errors++;
                $display("FAIL fetch_grant k=%0d got i=%b d=%b addr=%0d", k, I_GNT, D_GNT, MEM_ADDRESS);
            end
            sb_push(k == 0, 1'b0);
        end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            drive(1'b0, 10'd0, k < 2, k == 0, 10'd3, k == 0 ? 32'h0000_00A5 : 32'h0);
            @(negedge CLK);
            checks++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (I_RVALID !== !e.is_d || D_RVALID !== e.is_d || (e.is_d ? D_RDATA : I_RDATA) !== e.data) begin
                    errors++;
                    $display("FAIL wr_resp got i_v=%b d_v=%b i_d=%h d_d=%h want d=%b data=%h", I_RVALID, D_RVALID, I_RDATA, D_RDATA, e.is_d, e.data);
                end
            end else if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0) begin
                errors++;
                $display("FAIL wr_spurious got i_v=%b d_v=%b want 0 0", I_RVALID, D_RVALID);
            end
            checks++;
            if (D_GNT !== (k < 2) || I_GNT !== 1'b0 || MEM_WRITE_ENABLE !== (k == 0)
                || MEM_WRITE_DATA !== (k == 0 ? 32'h0000_00A5 : 32'h0)) begin
                errors++;
                $display("FAIL wr_grant k=%0d got d=%b we=%b wdata=%h", k, D_GNT, MEM_WRITE_ENABLE, MEM_WRITE_DATA);
            end
            sb_push(1'b0, k < 2);
        end
    endtask

    task automatic test_starvation();
        int ig = 0;
        for (int k = 0; k < 10; k++) begin
            bit ei = (k % 5) == 4;
            @(posedge CLK); #1;
            drive(1'b1, 10'(200 + ig), 1'b1, 1'b0, 10'(100 + k), 32'h0);
            @(negedge CLK);
            checks++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (I_RVALID !== !e.is_d || D_RVALID !== e.is_d || (e.is_d ? D_RDATA : I_RDATA) !== e.data) begin
                    errors++;
                    $display("FAIL starve_resp got i_v=%b d_v=%b i_d=%h d_d=%h want d=%b data=%h", I_RVALID, D_RVALID, I_RDATA, D_RDATA, e.is_d, e.data);
                end
            end else if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0) begin
                errors++;
                $display("FAIL starve_spurious got i_v=%b d_v=%b want 0 0", I_RVALID, D_RVALID);
            end
            checks++;
            if (I_GNT !== ei || D_GNT !== !ei) begin
                errors++;
                $display("FAIL starve_grant k=%0d got i=%b d=%b want i=%b d=%b", k, I_GNT, D_GNT, ei, !ei);
            end
            sb_push(ei, !ei);
            if (ei) ig++;
        end
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 8; k++) begin
            bit is_d = (k % 2) == 1;
            @(posedge CLK); #1;
            drive(!is_d, 10'(20 + k), is_d, (k % 4) == 1, 10'd40, 32'h1000_0000 + 32'(k));
            @(negedge CLK);
            checks++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (I_RVALID !== !e.is_d || D_RVALID !== e.is_d || (e.is_d ? D_RDATA : I_RDATA) !== e.data) begin
                    errors++;
                    $display("FAIL alt_resp k=%0d got i_v=%b d_v=%b i_d=%h d_d=%h want d=%b data=%h", k, I_RVALID, D_RVALID, I_RDATA, D_RDATA, e.is_d, e.data);
                end
            end else if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0) begin
                errors++;
                $display("FAIL alt_spurious got i_v=%b d_v=%b want 0 0", I_RVALID, D_RVALID);
            end
            checks++;
            if (I_GNT !== !is_d || D_GNT !== is_d || MEM_ENABLED !== 1'b1
                || MEM_ADDRESS !== (is_d ? 10'd40 : 10'(20 + k))) begin
                errors++;
                $display("FAIL alt_grant k=%0d got i=%b d=%b en=%b addr=%0d", k, I_GNT, D_GNT, MEM_ENABLED, MEM_ADDRESS);
            end
            sb_push(!is_d, is_d);
        end
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < 9; k++) begin
            bit rst = (k == 3);
            bit ei  = (k == 8);
            bit ed  = !rst && !ei;
            @(posedge CLK); #1;
            RST = rst;
            drive(1'b1, 10'd9, 1'b1, 1'b0, 10'd7, 32'h0);
            @(negedge CLK);
            if (rst) sbq.delete();
            checks++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (I_RVALID !== !e.is_d || D_RVALID !== e.is_d || (e.is_d ? D_RDATA : I_RDATA) !== e.data) begin
                    errors++;
                    $display("FAIL abort_resp k=%0d got i_v=%b d_v=%b i_d=%h d_d=%h want d=%b data=%h", k, I_RVALID, D_RVALID, I_RDATA, D_RDATA, e.is_d, e.data);
                end
            end else if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0) begin
                errors++;
                $display("FAIL abort_spurious k=%0d got i_v=%b d_v=%b want 0 0", k, I_RVALID, D_RVALID);
            end
            checks++;
            if (I_GNT !== ei || D_GNT !== ed) begin
                errors++;
                $display("FAIL abort_grant k=%0d got i=%b d=%b want i=%b d=%b", k, I_GNT, D_GNT, ei, ed);
            end
            sb_push(ei, ed);
        end
        RST = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            drive(1'b0, 10'd11, 1'b0, 1'b1, 10'd12, 32'hFFFF_FFFF);
            @(negedge CLK);
            checks++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (I_RVALID !== !e.is_d || D_RVALID !== e.is_d || (e.is_d ? D_RDATA : I_RDATA) !== e.data) begin
                    errors++;
                    $display("FAIL idle_resp got i_v=%b d_v=%b i_d=%h d_d=%h want d=%b data=%h", I_RVALID, D_RVALID, I_RDATA, D_RDATA, e.is_d, e.data);
                end
            end else if (I_RVALID !== 1'b0 || D_RVALID !== 1'b0) begin
                errors++;
                $display("FAIL idle_spurious got i_v=%b d_v=%b want 0 0", I_RVALID, D_RVALID);
            end
            checks++;
            if (MEM_ENABLED !== 1'b0 || MEM_WRITE_ENABLE !== 1'b0 || MEM_ADDRESS !== 10'd0
                || MEM_WRITE_DATA !== 32'h0 || I_GNT !== 1'b0 || D_GNT !== 1'b0) begin
                errors++;
                $display("FAIL idle_drive got en=%b we=%b addr=%0d wdata=%h want all 0", MEM_ENABLED, MEM_WRITE_ENABLE, MEM_ADDRESS, MEM_WRITE_DATA);
            end
        end
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mem_contents got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        mem_loaded = 1'b0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_fetch();
        test_write_read();
        test_starvation();
        test_alternate();
        test_reset_abort();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_mem_arbiter.md
Name: block_mem_arbiter

Overview:
- Shares the single-port 1024x32 block memory between two requesters: the instruction-fetch port (I) and the load/store data port (D).
- Sits between the pipeline front/back ends and block_memory, and drives its MEM_ENABLED, ADDRESS, WRITE_ENABLE and WRITE_DATA inputs.
- D has priority. An aging counter guarantees I is served within STARVE_LIMIT cycles.
- Read data returns one cycle after grant. A registered tag routes each response to its owner.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles I may be denied while requesting before I is forced ahead of D (1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- I_REQ  in  1  fetch request (read only); held until granted.
- I_ADDR  in  ADDR_W  fetch word address.
- I_GNT  out  1  fetch request accepted this cycle.
- I_RVALID  out  1  I_RDATA valid this cycle.
- I_RDATA  out  DATA_W  fetch data.
- D_REQ  in  1  data request; held with stable fields until granted.
- D_WE  in  1  1 = write, 0 = read.
- D_ADDR  in  ADDR_W  data word address.
- D_WDATA  in  DATA_W  write data.
- D_GNT  out  1  data request accepted this cycle.
- D_RVALID  out  1  read data valid, or write-complete ack.
- D_RDATA  out  DATA_W  load data; 0 for write acks.
- MEM_ENABLED  out  1  memory access this cycle.
- MEM_ADDRESS  out  ADDR_W  to memory.
- MEM_WRITE_ENABLE  out  1  to memory.
- MEM_WRITE_DATA  out  DATA_W  to memory.
- MEM_READ_DATA  in  DATA_W  memory registered read port (1-cycle latency).

Behaviour:
- Registered state:
  - tag_valid, tag_owner (I/D), tag_write.
  - wait_cnt (4-bit).
- Reset: while RST=1:
  - all grants 0; MEM_ENABLED=0; MEM_WRITE_ENABLE=0.
  - tag_valid and wait_cnt cleared.
  - next cycle I_RVALID=D_RVALID=0.
  - An access granted in the cycle before RST asserts produces no response.
- Grant decision (combinational, from requests and registered state):
  - starve = (wait_cnt >= STARVE_LIMIT).
  - D_GNT = D_REQ & !(I_REQ & starve).
  - I_GNT = I_REQ & !D_GNT.
  - At most one grant per cycle. Back-to-back grants every cycle are allowed (full throughput).
- Memory drive:
  - MEM_ENABLED = I_GNT | D_GNT.
  - Address and data are muxed from the granted port.
  - MEM_WRITE_ENABLE = D_GNT & D_WE.
  - When idle, address and write data are 0.
- Tag update on each edge: tag_valid <= grant; tag_owner <= granted port; tag_write <= D_WE.
- Responses (cycle N+1 after grant in cycle N):
  - I_RVALID = tag_valid & owner==I.
  - D_RVALID = tag_valid & owner==D.
  - I_RDATA = MEM_READ_DATA when I_RVALID, else 0.
  - D_RDATA = MEM_READ_DATA when D_RVALID and not tag_write, else 0.
  - No response backpressure: requesters must accept.
- Aging counter:
  - wait_cnt increments (saturating at 15) when I_REQ & !I_GNT.
  - Clears to 0 on I_GNT, or when I_REQ=0.
- Simultaneous requests:
  - D wins unless starve, in which case I wins and wait_cnt clears.
  - The denied requester holds its request.
- Address wrap: none. Addresses are native ADDR_W bits and all 1024 words are valid.
- Write-then-read to the same address in consecutive cycles returns the new data, because the write commits at edge N and the read samples at edge N+1.

Decomposition:
- Shared package def_pack gains:
  - typedef enum logic {OWNER_I, OWNER_D} mem_owner_t.
  - struct mem_tag_t {valid, owner, write}.
  - localparam MEM_ADDR_W = 10.
- No sub-module. The aging counter is inline.
- block_memory is instantiated beside the arbiter at the next level up, not inside it.

Test Plan:
- I_REQ only, I_ADDR=5, memory[5]=32'hDEADBEEF -> I_GNT same cycle; next cycle I_RVALID=1, I_RDATA=32'hDEADBEEF; D_RVALID=0.
- D write addr 3 data 32'h0000_00A5, then D read addr 3 next cycle -> D_RVALID ack with D_RDATA=0, then D_RVALID with D_RDATA=32'h0000_00A5.
- I_REQ and D_REQ held high continuously, STARVE_LIMIT=4 -> D granted 4 cycles, I granted 5th cycle, pattern repeats; I never waits more than 4 cycles.
- Alternating I/D grants every cycle -> MEM_ENABLED stays 1; responses arrive in order, each on the correct port, one cycle after its grant.
- D read granted at cycle N, RST=1 at cycle N+1 -> D_RVALID=0 at N+1 and N+2; wait_cnt=0; first grant after RST deasserts behaves normally.
- Both requests low -> MEM_ENABLED=0, MEM_WRITE_ENABLE=0, no RVALIDs; memory contents unchanged.
